// File: rtl/axi4_read_burst_master.sv
// AXI4 read master: splits one linear read request into INCR bursts that
// respect a maximum burst length and never cross a 4 KiB boundary, and
// forwards the returned beats on a valid/ready stream with an end marker.
module axi4_read_burst_master #(
    parameter int                  DATA_WIDTH    = 32,
    parameter int                  ADDR_WIDTH    = 32,
    parameter int                  ID_WIDTH      = 1,
    parameter int                  CNT_WIDTH     = 16,
    parameter int                  MAX_BURST_LEN = 256,
    parameter logic [ID_WIDTH-1:0] ID_VALUE      = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [CNT_WIDTH-1:0]  req_beats_m1,
    input  logic [3:0]            req_cache,
    input  logic [2:0]            req_prot,
    input  logic [3:0]            req_qos,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic [3:0]            m_axi_arregion,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,

    output logic                  done,
    output logic [1:0]            err_resp,
    output logic                  err_rlast
);

    localparam int SIZE = $clog2(DATA_WIDTH / 8);
    // Remaining-beat counters must hold 2^CNT_WIDTH and also the 4 KiB distance.
    localparam int RW   = (CNT_WIDTH + 1 > 13) ? CNT_WIDTH + 1 : 13;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

    typedef enum logic { IDLE,      BUSY      } top_state_t;
    typedef enum logic { ADDR_IDLE, ADDR_BUSY } addr_state_t;
    typedef enum logic { DATA_IDLE, DATA_BUSY } data_state_t;

    top_state_t  state,      state_next;
    addr_state_t addr_state, addr_next;
    data_state_t data_state, data_next;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [RW-1:0]         ar_remaining;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;

    logic [ADDR_WIDTH-1:0] data_addr;
    logic [RW-1:0]         data_remaining;
    logic [8:0]            beat_cnt;
    logic [8:0]            burst_len;

    logic                  done_q;
    logic [1:0]            err_resp_q;
    logic                  err_rlast_q;

    logic                  req_fire, ar_fire, r_fire;
    logic                  ar_on, burst_end, final_beat;
    logic [8:0]            ar_beats;
    logic [RW-1:0]         start_beats;
    logic [ADDR_WIDTH-1:0] start_addr, next_data_addr;
    logic                  unused_rid;

    // Beats in the next burst: bounded by what is left, the burst cap and the 4 KiB page.
    function automatic logic [8:0] calc_beats(input logic [11:0] addr_lo,
                                              input logic [RW-1:0] remaining);
        logic [RW-1:0] to_boundary;
        logic [RW-1:0] lim;
        to_boundary = RW'((13'd4096 - {1'b0, addr_lo}) >> SIZE);
        lim = remaining;
        if (RW'(MAX_BURST_LEN) < lim) lim = RW'(MAX_BURST_LEN);
        if (to_boundary < lim) lim = to_boundary;
        return lim[8:0];
    endfunction

    assign unused_rid     = ^m_axi_rid;

    assign start_addr     = req_addr & ALIGN_MASK;
    assign start_beats    = RW'(req_beats_m1) + RW'(1);
    assign req_fire       = req_valid && req_ready;
    assign ar_beats       = calc_beats(cur_addr[11:0], ar_remaining);
    assign ar_fire        = m_axi_arvalid && m_axi_arready;
    assign r_fire         = m_axi_rvalid && m_axi_rready;
    assign burst_end      = (beat_cnt == burst_len - 9'd1);
    assign final_beat     = (data_remaining == RW'(1));
    assign next_data_addr = data_addr + (ADDR_WIDTH'(burst_len) << SIZE);
    assign ar_on          = (addr_state == ADDR_BUSY);

    // Handshake flags and the zero-latency R-to-stream path; AR payload reads zero while idle.
    always_comb begin
        req_ready      = (state == IDLE);
        m_axi_arvalid  = ar_on;
        m_axi_arid     = ar_on ? ID_VALUE : '0;
        m_axi_araddr   = ar_on ? cur_addr : '0;
        m_axi_arlen    = ar_on ? 8'(ar_beats - 9'd1) : 8'd0;
        m_axi_arsize   = ar_on ? 3'(SIZE) : 3'd0;
        m_axi_arburst  = ar_on ? 2'b01 : 2'b00;
        m_axi_arlock   = 1'b0;
        m_axi_arcache  = ar_on ? ar_cache : 4'd0;
        m_axi_arprot   = ar_on ? ar_prot : 3'd0;
        m_axi_arqos    = ar_on ? ar_qos : 4'd0;
        m_axi_arregion = 4'd0;
        m_axi_rready   = dout_ready && (data_state == DATA_BUSY);
        dout_valid     = m_axi_rvalid && (data_state == DATA_BUSY);
        dout_data      = m_axi_rdata;
        dout_last      = (data_state == DATA_BUSY) && final_beat;
        done           = done_q;
        err_resp       = err_resp_q;
        err_rlast      = err_rlast_q;
    end

    // State registers for the top, address-side and data-side FSMs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_state <= ADDR_IDLE;
            data_state <= DATA_IDLE;
        end else begin
            state      <= state_next;
            addr_state <= addr_next;
            data_state <= data_next;
        end
    end

    // Next-state logic: request acceptance starts both sides, each side ends on its own.
    always_comb begin
        state_next = state;
        addr_next  = addr_state;
        data_next  = data_state;
        case (state)
            IDLE:    if (req_fire) state_next = BUSY;
            BUSY:    if (r_fire && final_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        case (addr_state)
            ADDR_IDLE: if (req_fire) addr_next = ADDR_BUSY;
            ADDR_BUSY: if (ar_fire && (ar_remaining == RW'(ar_beats))) addr_next = ADDR_IDLE;
            default:   addr_next = ADDR_IDLE;
        endcase
        case (data_state)
            DATA_IDLE: if (req_fire) data_next = DATA_BUSY;
            DATA_BUSY: if (r_fire && final_beat) data_next = DATA_IDLE;
            default:   data_next = DATA_IDLE;
        endcase
    end

    // Address side: walk the request one burst per AR handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr     <= '0;
            ar_remaining <= '0;
            ar_cache     <= '0;
            ar_prot      <= '0;
            ar_qos       <= '0;
        end else if (req_fire) begin
            cur_addr     <= start_addr;
            ar_remaining <= start_beats;
            ar_cache     <= req_cache;
            ar_prot      <= req_prot;
            ar_qos       <= req_qos;
        end else if (ar_fire) begin
            cur_addr     <= cur_addr + (ADDR_WIDTH'(ar_beats) << SIZE);
            ar_remaining <= ar_remaining - RW'(ar_beats);
        end
    end

    // Data side: re-derive burst lengths for rlast checking, track errors and the final beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_addr      <= '0;
            data_remaining <= '0;
            beat_cnt       <= '0;
            burst_len      <= '0;
            done_q         <= 1'b0;
            err_resp_q     <= 2'b00;
            err_rlast_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (req_fire) begin
                data_addr      <= start_addr;
                data_remaining <= start_beats;
                beat_cnt       <= '0;
                burst_len      <= calc_beats(start_addr[11:0], start_beats);
                err_resp_q     <= 2'b00;
                err_rlast_q    <= 1'b0;
            end else if (r_fire) begin
                data_remaining <= data_remaining - RW'(1);
                if (m_axi_rlast != burst_end) err_rlast_q <= 1'b1;
                if ((err_resp_q == 2'b00) && (m_axi_rresp != 2'b00)) err_resp_q <= m_axi_rresp;
                if (burst_end) begin
                    beat_cnt  <= '0;
                    data_addr <= next_data_addr;
                    burst_len <= calc_beats(next_data_addr[11:0], data_remaining - RW'(1));
                end else begin
                    beat_cnt  <= beat_cnt + 9'd1;
                end
                if (final_beat) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/axi4_read_burst_master.md
# axi4_read_burst_master

Parametrised AXI4 read master that turns one linear read request (start address plus beat count) into a sequence of INCR bursts. Each burst is limited by a configurable maximum burst length (AXI4 256 / AXI3 16) and never crosses a 4 KiB boundary. Read data goes out on a valid/ready stream with an end-of-request marker. Response and protocol errors are reported per request. The block sits between a DMA/stream engine and the interconnect, and is the burst-capable successor of the single-state AXI4 master FSM.

## Interface
- DATA_WIDTH, 32: R data width in bits; power of two, 8..1024.
- ADDR_WIDTH, 32: address width.
- ID_WIDTH, 1: ARID/RID width.
- CNT_WIDTH, 16: width of the request beat count.
- MAX_BURST_LEN, 256: beat cap per burst; 256 = AXI4, 16 = AXI3; must be a power of two, 1..256.
- ID_VALUE, 0: constant ARID; RID is not checked.
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid / req_ready  in / out  1  request handshake.
- req_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits are forced to 0.
- req_beats_m1  in  CNT_WIDTH  beats minus one (1..2^CNT_WIDTH beats).
- req_cache, req_prot, req_qos  in  4/3/4  copied onto every AR of the request.
- m_axi_arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0], arlock, arcache[3:0], arprot[2:0], arqos[3:0], arregion[3:0], arvalid  out  AR channel.
- m_axi_arready  in  1.
- m_axi_rid, rdata, rresp[1:0], rlast, rvalid  in  R channel.
- m_axi_rready  out  1.
- dout_data  out  DATA_WIDTH; dout_valid  out  1; dout_ready  in  1; dout_last  out  1 (final beat of request).
- done  out  1  one-cycle pulse at end of request.
- err_resp  out  2  first non-OKAY rresp of the request, OKAY if none; valid with done.
- err_rlast  out  1  rlast mismatch seen in the request; valid with done.

## Operation
- Top FSM: IDLE -> BUSY -> IDLE. req_ready = (state == IDLE). The request is captured on req_valid && req_ready.
- Address side (ADDR_IDLE/ADDR_BUSY): tracks cur_addr and ar_remaining (beats).
  - Burst beats = min(ar_remaining, MAX_BURST_LEN, (4096 - cur_addr[11:0]) >> SIZE), where SIZE = log2(DATA_WIDTH/8).
  - arlen = beats - 1.
  - On AR handshake: cur_addr += beats << SIZE and ar_remaining -= beats. At 0 the side moves to ADDR_IDLE.
- Constant AR fields: arsize = SIZE, arburst = INCR (2'b01), arlock = 0, arregion = 0, arid = ID_VALUE.
- Data side (DATA_IDLE/DATA_BUSY): independently re-runs the same split from the captured start address to know each burst's length. No length FIFO.
  - Counters: beat-in-burst and total remaining.
  - Outstanding bursts are unbounded; the data side never waits for AR to complete.
- R-to-stream path is combinational:
  - dout_valid = rvalid && DATA_BUSY.
  - m_axi_rready = dout_ready && DATA_BUSY.
  - dout_data = rdata.
  - dout_last = the request's final beat.
- rlast check, per beat: expected = (beat-in-burst == burst_len - 1). rlast != expected sets err_rlast (sticky until the next request). Beat counting follows the computed lengths, not rlast.
- err_resp latches the first rresp != OKAY. Later errors do not overwrite it. Data still streams.
- Request ends on the final R handshake. done pulses the next cycle, FSM goes to IDLE, and err_* hold until the next request is accepted, which clears them.

## Timing
- Reset values: req_ready 1 (state IDLE); arvalid, rready, dout_valid, dout_last, done all 0; err_resp 00; err_rlast 0; all AR payload 0.
- Request accepted in cycle N -> arvalid = 1 in N+1 with burst 0.
- AR payload is stable while arvalid && !arready.
- After an AR handshake the next burst is presented in the following cycle with arvalid kept high. This gives a back-to-back AR throughput of 1 burst/cycle.
- R path adds zero latency. Throughput is 1 beat/cycle with dout_ready held high.
- done is asserted exactly 1 cycle after the last R handshake. req_ready rises in the same cycle, so the next request can be accepted in that cycle.
- A request is never accepted while BUSY.
- Reset mid-request: all state clears on the next edge and arvalid/rready drop. In-flight AXI transactions are abandoned; the interconnect/slave must be reset together.
- An R beat arriving in DATA_IDLE is not accepted (rready = 0).

## Test plan
- Single beat, req_addr 0x100, beats_m1 0 -> one AR with araddr 0x100, arlen 0, arsize 2; one dout beat with dout_last=1; done one cycle later; err_resp 00.
- 300 beats at 0x0, MAX_BURST_LEN 256, DATA_WIDTH 32 -> AR bursts (0x0, arlen 255) and (0x400, arlen 43); dout_last only on beat 300.
- 4 KiB crossing: addr 0xFF0, 8 beats -> (0xFF0, arlen 3) then (0x1000, arlen 3).
- AXI3 mode, MAX_BURST_LEN 16: 40 beats at 0x2000 -> arlen 15, 15, 7; with arready held high, AR handshakes occur on consecutive cycles.
- Random dout_ready/arready/rvalid backpressure -> AR payload stable while stalled; no beat lost or duplicated; data order preserved.
- Slave sends SLVERR on beat 2 and DECERR on beat 5, and omits rlast on the last beat of burst 0 -> all beats still delivered; with done: err_resp 10, err_rlast 1. The next request starts with both flags cleared.
